pc_unit: RTL

//   Parametrised program-counter unit for the multi-cycle CPU; replaces the bare PC register.

---
 rtl/pc_unit_if.sv | 37 +++
 rtl/pc_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Control-side and fetch-side signals for the program-counter unit.
// The CPU control path drives through master; pc_unit connects through slave.
interface pc_unit_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic             pc_write;
  logic             branch_req;
  logic [WIDTH-1:0] branch_target;
  logic             jump_req;
  logic [WIDTH-1:0] jump_target;
  logic             link;
  logic             ret_req;
  logic             eret;
  logic             exc_req;

  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus_o;
  logic [WIDTH-1:0] epc_o;
  logic [CW-1:0]    ras_count_o;
  logic             ras_underflow_o;
  logic             misaligned_o;

  modport master (
    output pc_write, branch_req, branch_target, jump_req, jump_target,
           link, ret_req, eret, exc_req,
    input  pc_o, pc_plus_o, epc_o, ras_count_o, ras_underflow_o, misaligned_o
  );

  modport slave (
    input  pc_write, branch_req, branch_target, jump_req, jump_target,
           link, ret_req, eret, exc_req,
    output pc_o, pc_plus_o, epc_o, ras_count_o, ras_underflow_o, misaligned_o
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC selection, an EPC register for
// exception entry/return, and a circular return-address stack fed by linking jumps.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h8000_0004,
  parameter int unsigned      INC       = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.slave   bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_q, top_d;
  logic             udf_q, udf_d;
  logic             push;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign pc_plus = pc_q + WIDTH'(INC);

  // NOTE: every signal gets a default before the priority chain so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    cnt_d = cnt_q;
    top_d = top_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (bus.exc_req) begin
      epc_d = pc_q;
      pc_d  = EXC_VEC;
    end else if (bus.pc_write) begin
      if (bus.eret) begin
        pc_d = epc_q;
      end else if (bus.branch_req) begin
        pc_d = bus.branch_target;
      end else if (bus.jump_req) begin
        pc_d = bus.jump_target;
        if (bus.link) begin
          // A full stack keeps its count; the new top overwrites the oldest slot.
          push  = 1'b1;
          top_d = top_q + PW'(1);
          if (cnt_q != FULL) cnt_d = cnt_q + CW'(1);
        end
      end else if (bus.ret_req) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[top_q];
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = pc_plus;
          udf_d = 1'b1;
        end
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      cnt_q <= '0;
      top_q <= '0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      udf_q <= udf_d;
    end
  end

  // NOTE: stack storage has no reset; entries are only readable once pushed
  // after the count was cleared, so clearing them would add nothing.
  always_ff @(posedge clk) begin
    if (push && !reset) ras_q[top_d] <= pc_plus;
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_plus_o       = pc_plus;
  assign bus.epc_o           = epc_q;
  assign bus.ras_count_o     = cnt_q;
  assign bus.ras_underflow_o = udf_q;
  assign bus.misaligned_o    = (pc_q[1:0] != 2'b00);

endmodule
